hwpe_stream_lfsr_sink: RTL
==========================

Name: hwpe_stream_lfsr_sink

Overview:
Synthesizable stream sink (consumer end) for the hwpe_stream_intf_stream protocol. It accepts a programmable number of beats under pseudo-random backpressure and checks every beat against a locally regenerated LFSR data sequence. It also checks valid/data stability while stalled. It sits at the output of a streamer or datapath under test, in the same test harness as stream sources, and reports done, beat count, error count, first-error index and a sticky protocol-error flag.

Parameters:
DATA_WIDTH, 32, stream data width; must be a multiple of 32 (elaboration assertion otherwise).
CHECK_STRB, 1, 1 = strb must be all-ones on every beat; 0 = strb ignored.
ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
start_i  in  1  pulse: load configuration and begin a run
length_i  in  32  number of beats to accept in the run
seed_i  in  32  data LFSR seed; 0 is replaced by 1
stall_seed_i  in  16  stall LFSR seed; 0 is replaced by 1
stall_thr_i  in  8  backpressure threshold; 0 = never stall
force_ready_i  in  1  overrides stall: ready=1 while RUN
data_i  sink  hwpe_stream_intf_stream.sink (DATA_WIDTH)  data, strb, valid in; ready out
busy_o  out  1  state==RUN
done_o  out  1  state==DONE
beat_cnt_o  out  32  accepted beats in current/last run
err_cnt_o  out  ERR_CNT_WIDTH  mismatching beats, saturating
first_err_valid_o  out  1  at least one mismatch this run
first_err_idx_o  out  32  beat index of first mismatch
proto_err_o  out  1  sticky stability violation this run

Behaviour:
- Reset (rst_i=1 at a clk_i edge, from any state, including mid-run): state=IDLE; all outputs 0; data.ready=0; both LFSRs=1. Reset has priority over start_i.
- FSM states are IDLE, RUN and DONE.
- IDLE/DONE + start_i:
  - Latch length_i, load the data LFSR with seed_i and the stall LFSR with stall_seed_i (0→1).
  - Clear beat_cnt, err_cnt, first_err_* and proto_err.
  - If length_i==0, go to DONE; else go to RUN.
- start_i is ignored in RUN.
- RUN→DONE on the cycle the handshake with beat_cnt==length-1 occurs. done_o is 1 from the next cycle and is held until start_i or rst_i.
- Handshake = valid & ready at a clk_i edge.
- data.ready = (state==RUN) & (force_ready_i | stall_lfsr[7:0] >= stall_thr_i).
  - Ready depends only on registers and force_ready_i, never on valid.
  - Ready is 0 in IDLE/DONE.
- Stall LFSR: 16-bit Galois, right shift: next = (s>>1) ^ (s[0] ? 16'hB400 : 0). It advances every cycle in RUN and is frozen otherwise.
- Data LFSR: 32-bit Galois, same form, mask 32'h80200003.
  - Expected beat: lane 0 (bits 31:0) = current state s0; lane j = s_j, where s_j is s0 advanced j times.
  - On handshake, the state advances DATA_WIDTH/32 steps, so the next beat starts at s_(DATA_WIDTH/32).
  - The state does not advance without a handshake.
- Check on handshake:
  - mismatch = (data != expected) | (CHECK_STRB & strb != '1).
  - On mismatch, err_cnt increments, saturating at all-ones.
  - If first_err_valid_o==0, set it and capture first_err_idx_o = beat_cnt.
  - beat_cnt increments on every handshake.
- Stability check (RUN only): register valid, ~ready, data and strb each cycle. proto_err_o sets (sticky) if the previous cycle had valid=1, ready=0 and the current cycle has:
  - valid=0, or
  - data differs, or
  - strb differs.
  It is cleared only by start_i or rst_i.
- Latency: the first ready is possible in the cycle after start_i. Statistics update one cycle after the handshake edge, i.e. they are registered.

Decomposition:
- hwpe_stream_package: add the state typedef (IDLE, RUN, DONE) and localparams for the LFSR masks (HWPE_STREAM_LFSR32_MASK=32'h80200003, HWPE_STREAM_LFSR16_MASK=16'hB400).
- Sub-module hwpe_stream_lfsr_step: combinational Galois step with parameters WIDTH, MASK and STEPS. It returns the STEPS-advanced state plus every intermediate state, and supplies the expected lanes and the data-LFSR advance.
- The stall LFSR uses the same sub-module with STEPS=1.

Test Plan:
1. DATA_WIDTH=64, seed=1, length=4, thr=0; source drives the matching sequence (beat0 lane0=32'h00000001, lane1=32'h80200003, beat1 lane0=32'hC0300002, …) → ready=1 throughout RUN, 4 handshakes, done_o=1, beat_cnt=4, err_cnt=0, proto_err=0.
2. Same setup, beat 2 lane 0 corrupted by bit flip, beat 3 strb=8'h7F → err_cnt=2, first_err_idx=2, later beats still expected from the uncorrupted sequence.
3. stall_thr_i=8'h80, stall_seed=16'hACE1, length=16, source always valid → ready toggles per the LFSR formula, exactly 16 handshakes, err_cnt=0; force_ready_i=1 rerun → 16 consecutive ready cycles.
4. Source drops valid while ready=0 (then retries) → proto_err_o=1 and stays 1 through DONE until the next start_i clears it.
5. length_i=0 with start_i → DONE next cycle, ready never asserted, beat_cnt=0; start_i during RUN ignored (beat_cnt unchanged).
6. rst_i asserted after 3 of 8 beats → next cycle IDLE, all outputs 0, ready=0; new start with same seed → sequence restarts at seed, 8 beats, err_cnt=0.

Source files
------------

// File: rtl/hwpe_stream_lfsr_sink_pkg.sv
// Shared types and constants for the LFSR-checked stream sink.
// Holds the sink FSM state type and the Galois LFSR feedback masks.
package hwpe_stream_package;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] HWPE_STREAM_LFSR32_MASK = 32'h80200003;
    localparam logic [15:0] HWPE_STREAM_LFSR16_MASK = 16'hB400;

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    function automatic logic [31:0] nz32(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    function automatic logic [15:0] nz16(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle with data and byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_lfsr_step.sv
// Combinational right-shift Galois LFSR advanced STEPS times.
// o_chain holds states s_0..s_(STEPS-1); o_next is s_STEPS.
module hwpe_stream_lfsr_step #(
    parameter int unsigned       WIDTH = 32,
    parameter logic [WIDTH-1:0]  MASK  = '1,
    parameter int unsigned       STEPS = 1
) (
    input  logic [WIDTH-1:0]       i_state,
    output logic [WIDTH-1:0]       o_next,
    output logic [STEPS*WIDTH-1:0] o_chain
);

    logic [WIDTH-1:0] w_s;

    always_comb begin
        w_s     = i_state;
        o_chain = '0;
        for (int unsigned j = 0; j < STEPS; j++) begin
            o_chain[j*WIDTH +: WIDTH] = w_s;
            w_s = (w_s >> 1) ^ (w_s[0] ? MASK : '0);
        end
        o_next = w_s;
    end

endmodule

// File: rtl/hwpe_stream_lfsr_sink.sv
// Stream sink checking beats against a regenerated LFSR sequence
// under pseudo-random backpressure, plus valid/data stability.
module hwpe_stream_lfsr_sink
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CHECK_STRB    = 1,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [31:0]              length_i,
    input  logic [31:0]              seed_i,
    input  logic [15:0]              stall_seed_i,
    input  logic [7:0]               stall_thr_i,
    input  logic                     force_ready_i,
    hwpe_stream_intf_stream.sink     data_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [31:0]              beat_cnt_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
    output logic                     first_err_valid_o,
    output logic [31:0]              first_err_idx_o,
    output logic                     proto_err_o
);

    localparam int unsigned LANES = DATA_WIDTH / 32;
    localparam int unsigned SW    = DATA_WIDTH / 8;

    if (DATA_WIDTH % 32 != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 32");
    end

    state_t                   r_state, w_state_nxt;
    logic [31:0]              r_len, r_lfsr, w_lfsr_nxt;
    logic [31:0]              r_beat_cnt, r_first_idx;
    logic [15:0]              r_stall, w_stall_nxt;
    logic [7:0]               w_stall_lo, w_stall_unused_hi;
    logic [DATA_WIDTH-1:0]    w_expected, r_prev_data;
    logic [SW-1:0]            r_prev_strb;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
    logic                     r_first_valid, r_proto_err, r_prev_stall;
    logic                     w_run, w_start, w_ready, w_hs, w_last;
    logic                     w_strb_bad, w_mismatch, w_unstable;

    hwpe_stream_lfsr_step #(
        .WIDTH (32),
        .MASK  (HWPE_STREAM_LFSR32_MASK),
        .STEPS (LANES)
    ) i_data_lfsr (
        .i_state (r_lfsr),
        .o_next  (w_lfsr_nxt),
        .o_chain (w_expected)
    );

    hwpe_stream_lfsr_step #(
        .WIDTH (16),
        .MASK  (HWPE_STREAM_LFSR16_MASK),
        .STEPS (1)
    ) i_stall_lfsr (
        .i_state (r_stall),
        .o_next  (w_stall_nxt),
        .o_chain ({w_stall_unused_hi, w_stall_lo})
    );

    assign w_run   = (r_state == RUN);
    assign w_start = start_i & ~w_run;
    assign w_ready = w_run & (force_ready_i | (w_stall_lo >= stall_thr_i));
    assign w_hs    = data_i.valid & w_ready;
    assign w_last  = (r_beat_cnt == r_len - 32'd1);

    assign w_strb_bad = (CHECK_STRB != 0) && (data_i.strb != '1);
    assign w_mismatch = (data_i.data != w_expected) | w_strb_bad;
    assign w_unstable = ~data_i.valid
                      | (data_i.data != r_prev_data)
                      | (data_i.strb != r_prev_strb);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (start_i)
                    w_state_nxt = (length_i == 32'd0) ? DONE : RUN;
            end
            RUN: begin
                if (w_hs && w_last) w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_len         <= '0;
            r_lfsr        <= 32'd1;
            r_stall       <= 16'd1;
            r_beat_cnt    <= '0;
            r_err_cnt     <= '0;
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
            r_proto_err   <= 1'b0;
            r_prev_stall  <= 1'b0;
            r_prev_data   <= '0;
            r_prev_strb   <= '0;
        end else if (w_start) begin
            r_len         <= length_i;
            r_lfsr        <= nz32(seed_i);
            r_stall       <= nz16(stall_seed_i);
            r_beat_cnt    <= '0;
            r_err_cnt     <= '0;
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
            r_proto_err   <= 1'b0;
            r_prev_stall  <= 1'b0;
        end else if (w_run) begin
            r_stall      <= w_stall_nxt;
            r_prev_stall <= data_i.valid & ~w_ready;
            r_prev_data  <= data_i.data;
            r_prev_strb  <= data_i.strb;
            if (r_prev_stall && w_unstable) r_proto_err <= 1'b1;
            if (w_hs) begin
                r_lfsr     <= w_lfsr_nxt;
                r_beat_cnt <= r_beat_cnt + 32'd1;
                if (w_mismatch) begin
                    if (~&r_err_cnt) r_err_cnt <= r_err_cnt + 1'b1;
                    if (!r_first_valid) begin
                        r_first_valid <= 1'b1;
                        r_first_idx   <= r_beat_cnt;
                    end
                end
            end
        end
    end

    assign data_i.ready      = w_ready;
    assign busy_o            = w_run;
    assign done_o            = (r_state == DONE);
    assign beat_cnt_o        = r_beat_cnt;
    assign err_cnt_o         = r_err_cnt;
    assign first_err_valid_o = r_first_valid;
    assign first_err_idx_o   = r_first_idx;
    assign proto_err_o       = r_proto_err;

endmodule
